// File: rtl/hpu_alu_resolve.sv
// ALU resolve stage: registers the execute result, drives regfile writeback and the ROB
// completion report, and raises a held fetch redirect on a control-flow misprediction.

package hpu_pkg;
  typedef enum logic [2:0] {
    ALG  = 3'd0,
    UP   = 3'd1,
    JAL  = 3'd2,
    JALR = 3'd3,
    BR   = 3'd4
  } optype_e;

  typedef enum logic [3:0] {
    INST_ADDR_MISALIGNED = 4'd0,
    INST_ACCESS_FAULT    = 4'd1,
    ILLEGAL_INST         = 4'd2
  } excp_e;
endpackage

module hpu_alu_resolve
  import hpu_pkg::*;
#(
  parameter int unsigned PHY_W = 6,
  parameter int unsigned ROB_W = 5,
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [2:0]       in_optype_i,
  input  logic             in_rdst_en_i,
  input  logic [PHY_W-1:0] in_phy_rdst_i,
  input  logic [ROB_W-1:0] in_rob_id_i,
  input  logic [31:0]      in_data_i,
  input  logic             in_br_taken_i,
  input  logic [31:0]      in_next_pc_i,
  input  logic [31:0]      in_pred_pc_i,
  input  logic             flush_i,
  output logic             wb_en_o,
  output logic [PHY_W-1:0] wb_idx_o,
  output logic [31:0]      wb_data_o,
  output logic             cmt_valid_o,
  output logic [ROB_W-1:0] cmt_rob_id_o,
  output logic             cmt_mispred_o,
  output logic             cmt_br_taken_o,
  output logic             cmt_excp_en_o,
  output excp_e            cmt_excp_o,
  output logic             redir_valid_o,
  output logic [31:0]      redir_pc_o,
  input  logic             redir_ready_i,
  output logic [CNT_W-1:0] mispred_cnt_o
);

  typedef enum logic [0:0] {StIdle, StRedirWait} state_e;

  localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e             state_q, state_d;
  logic               wb_en_q, wb_en_d;
  logic [PHY_W-1:0]   wb_idx_q, wb_idx_d;
  logic [31:0]        wb_data_q, wb_data_d;
  logic               cmt_valid_q, cmt_valid_d;
  logic [ROB_W-1:0]   cmt_rob_id_q, cmt_rob_id_d;
  logic               cmt_mispred_q, cmt_mispred_d;
  logic               cmt_br_taken_q, cmt_br_taken_d;
  logic               cmt_excp_en_q, cmt_excp_en_d;
  logic [31:0]        redir_pc_q, redir_pc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  optype_e     op;
  logic        is_ctrl;
  logic [31:0] actual_pc;
  logic        misaligned;
  logic        mispred;
  logic        capture;

  // Decode the incoming result: resolved target, misalignment and misprediction.
  always_comb begin
    op         = optype_e'(in_optype_i);
    is_ctrl    = 1'b0;
    actual_pc  = in_next_pc_i;
    case (op)
      JAL, BR: is_ctrl = 1'b1;
      JALR: begin
        is_ctrl   = 1'b1;
        actual_pc = {in_next_pc_i[31:1], 1'b0};
      end
      default: is_ctrl = 1'b0;
    endcase
    misaligned = is_ctrl && (actual_pc[1:0] != 2'b00);
    // A misaligned target is reported as an exception, never as a redirect.
    mispred    = is_ctrl && !misaligned && (actual_pc != in_pred_pc_i);
    capture    = in_valid_i && (state_q == StIdle) && !flush_i;
  end

  // Next-state for the report registers, the redirect FSM and the counter.
  always_comb begin
    state_d        = state_q;
    wb_en_d        = 1'b0;
    wb_idx_d       = wb_idx_q;
    wb_data_d      = wb_data_q;
    cmt_valid_d    = 1'b0;
    cmt_rob_id_d   = cmt_rob_id_q;
    cmt_mispred_d  = 1'b0;
    cmt_br_taken_d = 1'b0;
    cmt_excp_en_d  = 1'b0;
    redir_pc_d     = redir_pc_q;
    cnt_d          = cnt_q;

    if (capture) begin
      wb_en_d        = in_rdst_en_i;
      wb_idx_d       = in_phy_rdst_i;
      wb_data_d      = in_data_i;
      cmt_valid_d    = 1'b1;
      cmt_rob_id_d   = in_rob_id_i;
      cmt_mispred_d  = mispred;
      cmt_br_taken_d = in_br_taken_i;
      cmt_excp_en_d  = misaligned;
      if (mispred) begin
        redir_pc_d = actual_pc;
        cnt_d      = cnt_q + CntOne;
      end
    end

    case (state_q)
      StIdle:      if (capture && mispred) state_d = StRedirWait;
      StRedirWait: if (redir_ready_i) state_d = StIdle;
      default:     state_d = StIdle;
    endcase

    // Flush abandons any pending redirect; a same-cycle handshake has no extra effect.
    if (flush_i) state_d = StIdle;
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q        <= StIdle;
      wb_en_q        <= 1'b0;
      wb_idx_q       <= '0;
      wb_data_q      <= '0;
      cmt_valid_q    <= 1'b0;
      cmt_rob_id_q   <= '0;
      cmt_mispred_q  <= 1'b0;
      cmt_br_taken_q <= 1'b0;
      cmt_excp_en_q  <= 1'b0;
      redir_pc_q     <= '0;
      cnt_q          <= '0;
    end else begin
      state_q        <= state_d;
      wb_en_q        <= wb_en_d;
      wb_idx_q       <= wb_idx_d;
      wb_data_q      <= wb_data_d;
      cmt_valid_q    <= cmt_valid_d;
      cmt_rob_id_q   <= cmt_rob_id_d;
      cmt_mispred_q  <= cmt_mispred_d;
      cmt_br_taken_q <= cmt_br_taken_d;
      cmt_excp_en_q  <= cmt_excp_en_d;
      redir_pc_q     <= redir_pc_d;
      cnt_q          <= cnt_d;
    end
  end

  assign in_ready_o     = (state_q == StIdle);
  assign wb_en_o        = wb_en_q;
  assign wb_idx_o       = wb_idx_q;
  assign wb_data_o      = wb_data_q;
  assign cmt_valid_o    = cmt_valid_q;
  assign cmt_rob_id_o   = cmt_rob_id_q;
  assign cmt_mispred_o  = cmt_mispred_q;
  assign cmt_br_taken_o = cmt_br_taken_q;
  assign cmt_excp_en_o  = cmt_excp_en_q;
  // Misalignment is the only cause this stage can raise.
  assign cmt_excp_o     = INST_ADDR_MISALIGNED;
  assign redir_valid_o  = (state_q == StRedirWait);
  assign redir_pc_o     = redir_pc_q;
  assign mispred_cnt_o  = cnt_q;

endmodule

// File: tb/tb_hpu_alu_resolve.sv
// Self-checking bench for hpu_alu_resolve: directed scenarios plus a randomized run
// against a behavioural model of the resolve rules.

module tb_hpu_alu_resolve;
  import hpu_pkg::*;

  localparam int unsigned PHY_W = 6;
  localparam int unsigned ROB_W = 5;
  localparam int unsigned CNT_W = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       in_optype;
  logic             in_rdst_en;
  logic [PHY_W-1:0] in_phy_rdst;
  logic [ROB_W-1:0] in_rob_id;
  logic [31:0]      in_data;
  logic             in_br_taken;
  logic [31:0]      in_next_pc;
  logic [31:0]      in_pred_pc;
  logic             flush;
  logic             wb_en;
  logic [PHY_W-1:0] wb_idx;
  logic [31:0]      wb_data;
  logic             cmt_valid;
  logic [ROB_W-1:0] cmt_rob_id;
  logic             cmt_mispred;
  logic             cmt_br_taken;
  logic             cmt_excp_en;
  excp_e            cmt_excp;
  logic             redir_valid;
  logic [31:0]      redir_pc;
  logic             redir_ready;
  logic [CNT_W-1:0] mispred_cnt;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] exp_cnt = '0;

  hpu_alu_resolve #(.PHY_W(PHY_W), .ROB_W(ROB_W), .CNT_W(CNT_W)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .in_valid_i    (in_valid),
    .in_ready_o    (in_ready),
    .in_optype_i   (in_optype),
    .in_rdst_en_i  (in_rdst_en),
    .in_phy_rdst_i (in_phy_rdst),
    .in_rob_id_i   (in_rob_id),
    .in_data_i     (in_data),
    .in_br_taken_i (in_br_taken),
    .in_next_pc_i  (in_next_pc),
    .in_pred_pc_i  (in_pred_pc),
    .flush_i       (flush),
    .wb_en_o       (wb_en),
    .wb_idx_o      (wb_idx),
    .wb_data_o     (wb_data),
    .cmt_valid_o   (cmt_valid),
    .cmt_rob_id_o  (cmt_rob_id),
    .cmt_mispred_o (cmt_mispred),
    .cmt_br_taken_o(cmt_br_taken),
    .cmt_excp_en_o (cmt_excp_en),
    .cmt_excp_o    (cmt_excp),
    .redir_valid_o (redir_valid),
    .redir_pc_o    (redir_pc),
    .redir_ready_i (redir_ready),
    .mispred_cnt_o (mispred_cnt)
  );

  always #5 clk = ~clk;

  // One clock edge; outputs are then observed 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    in_valid    = 1'b0;
    in_optype   = 3'(ALG);
    in_rdst_en  = 1'b0;
    in_phy_rdst = '0;
    in_rob_id   = '0;
    in_data     = '0;
    in_br_taken = 1'b0;
    in_next_pc  = '0;
    in_pred_pc  = '0;
    flush       = 1'b0;
    redir_ready = 1'b0;
  endtask

  task automatic drive(input optype_e op, input logic rd_en, input logic [PHY_W-1:0] phy,
                       input logic [ROB_W-1:0] rob, input logic [31:0] data,
                       input logic taken, input logic [31:0] npc, input logic [31:0] ppc);
    in_valid    = 1'b1;
    in_optype   = 3'(op);
    in_rdst_en  = rd_en;
    in_phy_rdst = phy;
    in_rob_id   = rob;
    in_data     = data;
    in_br_taken = taken;
    in_next_pc  = npc;
    in_pred_pc  = ppc;
  endtask

  task automatic test_reset();
    drive_idle();
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_cnt = '0;
    n_tests++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ready got %b exp 1", in_ready);
    end
    n_tests++;
    if ({wb_en, wb_idx, wb_data, cmt_valid, cmt_rob_id, cmt_mispred, cmt_br_taken, cmt_excp_en,
         redir_valid, redir_pc, mispred_cnt} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs wb=%b/%h/%h cmt=%b/%h/%b/%b/%b redir=%b/%h cnt=%h exp all 0",
               wb_en, wb_idx, wb_data, cmt_valid, cmt_rob_id, cmt_mispred, cmt_br_taken,
               cmt_excp_en, redir_valid, redir_pc, mispred_cnt);
    end
    n_tests++;
    if (cmt_excp !== INST_ADDR_MISALIGNED) begin
      n_fail++;
      $display("FAIL reset_cause got %0d exp %0d", cmt_excp, INST_ADDR_MISALIGNED);
    end
  endtask

  task automatic test_alg();
    drive(ALG, 1'b1, 6'd5, 5'd3, 32'h7, 1'b0, 32'h1234, 32'h9999);
    step();
    drive_idle();
    n_tests++;
    if ({wb_en, wb_idx, wb_data} !== {1'b1, 6'd5, 32'h7}) begin
      n_fail++;
      $display("FAIL alg_wb got %b/%0d/%h exp 1/5/7", wb_en, wb_idx, wb_data);
    end
    n_tests++;
    if ({cmt_valid, cmt_rob_id, cmt_mispred, cmt_excp_en, redir_valid} !==
        {1'b1, 5'd3, 1'b0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL alg_cmt got v=%b rob=%0d mp=%b ex=%b rv=%b exp 1/3/0/0/0",
               cmt_valid, cmt_rob_id, cmt_mispred, cmt_excp_en, redir_valid);
    end
    step();
    n_tests++;
    if ({wb_en, cmt_valid, cmt_mispred, cmt_excp_en} !== 4'b0) begin
      n_fail++;
      $display("FAIL alg_pulse got wb=%b cv=%b mp=%b ex=%b exp 0", wb_en, cmt_valid,
               cmt_mispred, cmt_excp_en);
    end
  endtask

  task automatic test_br_correct();
    drive(BR, 1'b0, 6'd0, 5'd9, 32'h0, 1'b1, 32'h100, 32'h100);
    step();
    drive_idle();
    n_tests++;
    if ({cmt_valid, cmt_mispred, cmt_br_taken, redir_valid, wb_en} !== 5'b10100 ||
        mispred_cnt !== exp_cnt) begin
      n_fail++;
      $display("FAIL br_ok got cv=%b mp=%b bt=%b rv=%b wb=%b cnt=%0d exp 1/0/1/0/0 cnt=%0d",
               cmt_valid, cmt_mispred, cmt_br_taken, redir_valid, wb_en, mispred_cnt, exp_cnt);
    end
  endtask

  task automatic test_br_mispred();
    drive(BR, 1'b0, 6'd0, 5'd10, 32'h0, 1'b1, 32'h200, 32'h104);
    step();
    exp_cnt++;
    drive_idle();
    n_tests++;
    if ({cmt_valid, cmt_mispred, redir_valid, in_ready} !== 4'b1110 || redir_pc !== 32'h200 ||
        mispred_cnt !== exp_cnt) begin
      n_fail++;
      $display("FAIL br_mp got cv=%b mp=%b rv=%b rdy=%b pc=%h cnt=%0d exp 1/1/1/0 200 cnt=%0d",
               cmt_valid, cmt_mispred, redir_valid, in_ready, redir_pc, mispred_cnt, exp_cnt);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      n_tests++;
      if ({redir_valid, in_ready, cmt_valid} !== 3'b100 || redir_pc !== 32'h200) begin
        n_fail++;
        $display("FAIL br_hold%0d got rv=%b rdy=%b cv=%b pc=%h exp 1/0/0 200", i, redir_valid,
                 in_ready, cmt_valid, redir_pc);
      end
    end
    // Handshake cycle; a valid input offered now must be ignored.
    redir_ready = 1'b1;
    drive(BR, 1'b1, 6'd1, 5'd11, 32'h55, 1'b1, 32'h700, 32'h0);
    step();
    drive_idle();
    n_tests++;
    if ({redir_valid, in_ready, cmt_valid, wb_en} !== 4'b0100 || mispred_cnt !== exp_cnt) begin
      n_fail++;
      $display("FAIL br_release got rv=%b rdy=%b cv=%b wb=%b cnt=%0d exp 0/1/0/0 cnt=%0d",
               redir_valid, in_ready, cmt_valid, wb_en, mispred_cnt, exp_cnt);
    end
  endtask

  task automatic test_jalr_jal();
    drive(JALR, 1'b1, 6'd7, 5'd4, 32'h8, 1'b1, 32'h301, 32'h300);
    step();
    n_tests++;
    if ({wb_en, wb_idx, wb_data, cmt_mispred, cmt_excp_en, redir_valid} !==
        {1'b1, 6'd7, 32'h8, 3'b000}) begin
      n_fail++;
      $display("FAIL jalr got wb=%b/%0d/%h mp=%b ex=%b rv=%b exp 1/7/8 0/0/0", wb_en, wb_idx,
               wb_data, cmt_mispred, cmt_excp_en, redir_valid);
    end
    drive(JAL, 1'b1, 6'd8, 5'd5, 32'h44, 1'b1, 32'h302, 32'h400);
    step();
    drive_idle();
    n_tests++;
    if ({cmt_valid, cmt_excp_en, cmt_mispred, wb_en} !== 4'b1101 ||
        cmt_excp !== INST_ADDR_MISALIGNED || wb_data !== 32'h44) begin
      n_fail++;
      $display("FAIL jal_excp got cv=%b ex=%b mp=%b wb=%b cause=%0d d=%h exp 1/1/0/1 0 44",
               cmt_valid, cmt_excp_en, cmt_mispred, wb_en, cmt_excp, wb_data);
    end
    step();
    n_tests++;
    if (redir_valid !== 1'b0 || in_ready !== 1'b1 || mispred_cnt !== exp_cnt) begin
      n_fail++;
      $display("FAIL jal_noredir got rv=%b rdy=%b cnt=%0d exp 0/1 cnt=%0d", redir_valid,
               in_ready, mispred_cnt, exp_cnt);
    end
  endtask

  task automatic test_flush_redir();
    drive(BR, 1'b0, 6'd0, 5'd12, 32'h0, 1'b0, 32'h500, 32'h504);
    step();
    exp_cnt++;
    drive_idle();
    n_tests++;
    if (redir_valid !== 1'b1 || redir_pc !== 32'h500) begin
      n_fail++;
      $display("FAIL flush_pre got rv=%b pc=%h exp 1 500", redir_valid, redir_pc);
    end
    flush = 1'b1;
    drive(BR, 1'b1, 6'd2, 5'd13, 32'h66, 1'b1, 32'h600, 32'h0);
    step();
    drive_idle();
    n_tests++;
    if ({redir_valid, cmt_valid, wb_en, in_ready} !== 4'b0001 || mispred_cnt !== exp_cnt) begin
      n_fail++;
      $display("FAIL flush_redir got rv=%b cv=%b wb=%b rdy=%b cnt=%0d exp 0/0/0/1 cnt=%0d",
               redir_valid, cmt_valid, wb_en, in_ready, mispred_cnt, exp_cnt);
    end
  endtask

  task automatic test_reset_redir();
    drive(JAL, 1'b1, 6'd3, 5'd14, 32'h9, 1'b1, 32'h800, 32'h804);
    step();
    exp_cnt++;
    drive_idle();
    n_tests++;
    if (redir_valid !== 1'b1 || mispred_cnt !== exp_cnt) begin
      n_fail++;
      $display("FAIL rst_pre got rv=%b cnt=%0d exp 1 cnt=%0d", redir_valid, mispred_cnt, exp_cnt);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_cnt = '0;
    n_tests++;
    if ({redir_valid, wb_en, cmt_valid, cmt_mispred, in_ready} !== 5'b00001 ||
        mispred_cnt !== '0 || redir_pc !== '0) begin
      n_fail++;
      $display("FAIL rst_redir got rv=%b wb=%b cv=%b mp=%b rdy=%b cnt=%0d pc=%h exp 0/0/0/0/1 0 0",
               redir_valid, wb_en, cmt_valid, cmt_mispred, in_ready, mispred_cnt, redir_pc);
    end
  endtask

  // Randomized traffic against a model of the resolve rules.
  task automatic test_random();
    bit          m_redir = 1'b0;
    logic [31:0] m_pc    = '0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      int unsigned op_n;
      logic [31:0] npc, act, ppc;
      bit          ctrl, misal, mp, cap;
      op_n = $urandom_range(0, 4);
      npc  = $urandom;
      if ($urandom_range(0, 3) != 0) npc = npc - (npc % 4) + ((op_n == 3) ? $urandom_range(0, 1) : 0);
      ctrl  = (op_n >= 2);
      act   = (op_n == 3) ? npc - (npc % 2) : npc;
      misal = ctrl && (act % 4 != 0);
      ppc   = ($urandom_range(0, 1) != 0) ? act : $urandom;
      mp    = ctrl && !misal && (act != ppc);
      drive(optype_e'(3'(op_n)), 1'($urandom_range(0, 1)), 6'($urandom), 5'($urandom), $urandom,
            1'($urandom_range(0, 1)), npc, ppc);
      in_valid    = ($urandom_range(0, 3) != 0);
      flush       = ($urandom_range(0, 15) == 0);
      redir_ready = ($urandom_range(0, 2) == 0);
      n_tests++;
      if (in_ready !== !m_redir) begin
        n_fail++;
        $display("FAIL rnd%0d_ready got %b exp %b", cyc, in_ready, !m_redir);
      end
      cap = in_valid && !m_redir && !flush;
      if (flush) m_redir = 1'b0;
      else if (m_redir && redir_ready) m_redir = 1'b0;
      else if (cap && mp) begin
        m_redir = 1'b1;
        m_pc    = act;
      end
      if (cap && mp) exp_cnt++;
      begin
        logic             e_wb    = cap && in_rdst_en;
        logic [PHY_W-1:0] e_idx   = in_phy_rdst;
        logic [31:0]      e_data  = in_data;
        logic [ROB_W-1:0] e_rob   = in_rob_id;
        logic             e_taken = in_br_taken;
        step();
        n_tests++;
        if (wb_en !== e_wb || (e_wb && (wb_idx !== e_idx || wb_data !== e_data))) begin
          n_fail++;
          $display("FAIL rnd%0d_wb got %b/%0d/%h exp %b/%0d/%h", cyc, wb_en, wb_idx, wb_data,
                   e_wb, e_idx, e_data);
        end
        n_tests++;
        if (cmt_valid !== cap ||
            (cap && {cmt_rob_id, cmt_mispred, cmt_br_taken, cmt_excp_en} !==
                    {e_rob, mp, e_taken, misal}) ||
            (!cap && {cmt_mispred, cmt_br_taken, cmt_excp_en} !== 3'b000)) begin
          n_fail++;
          $display("FAIL rnd%0d_cmt got %b/%0d/%b/%b/%b exp %b/%0d/%b/%b/%b", cyc, cmt_valid,
                   cmt_rob_id, cmt_mispred, cmt_br_taken, cmt_excp_en, cap, e_rob, mp, e_taken,
                   misal);
        end
      end
      n_tests++;
      if (redir_valid !== m_redir || (m_redir && redir_pc !== m_pc) || mispred_cnt !== exp_cnt) begin
        n_fail++;
        $display("FAIL rnd%0d_redir got %b/%h cnt=%0d exp %b/%h cnt=%0d", cyc, redir_valid,
                 redir_pc, mispred_cnt, m_redir, m_pc, exp_cnt);
      end
      drive_idle();
    end
  endtask

  initial begin
    rst = 1'b1;
    drive_idle();
    step();
    test_reset();
    test_alg();
    test_br_correct();
    test_br_mispred();
    test_jalr_jal();
    test_flush_redir();
    test_reset_redir();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

endmodule
